// File: rtl/led_pkg.sv
// Shared types, defaults and the round-robin picker for the LED bank blocks.
package led_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OPEN} state_e;

  localparam int LED_NUM_DEF  = 8;
  localparam int CLK_FREQ_DEF = 300_000_000;
  localparam int MAX_REQ      = 32;

  // First set bit of req found by searching upward from last+1, wrapping at n.
  // Returns last when req is empty.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int n);
    int idx;
    rr_pick = last;
    for (int i = n; i >= 1; i--) begin
      idx = last + i;
      if (idx >= n) idx = idx - n;
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Time-base prescaler: one-cycle tick every CLK_FREQ/TICK_HZ clocks.
module led_tick_gen #(
  parameter int CLK_FREQ = 300_000_000,
  parameter int TICK_HZ  = 1_000
) (
  input  logic CLK_i,
  input  logic RSTn_i,
  output logic tick
);

  localparam int DIV = (TICK_HZ > 0) ? CLK_FREQ / TICK_HZ : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (TICK_HZ < 1 || DIV < 1 || (CLK_FREQ % TICK_HZ) != 0) begin : g_bad_div
    $error("led_tick_gen: CLK_FREQ must be a positive integer multiple of TICK_HZ");
  end

  logic [CW-1:0] presc;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge CLK_i) begin
    if (!RSTn_i) presc <= '0;
    else if (presc == CW'(DIV - 1)) presc <= '0;
    else presc <= presc + 1'b1;
  end

  assign tick = (presc == CW'(DIV - 1));

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin sharing of the LED bank with a minimum hold time per grant;
// an idle running light is shown whenever nobody owns the bank.
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int CLK_FREQ    = CLK_FREQ_DEF,
  parameter int TICK_HZ     = 1_000,
  parameter int LED_NUM     = LED_NUM_DEF,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_TICKS  = 500,
  parameter int WATER_TICKS = 100,
  localparam int OW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       CLK_i,
  input  logic                       RSTn_i,
  input  logic [NUM_REQ-1:0]         REQ_i,
  input  logic [NUM_REQ*LED_NUM-1:0] PAT_i,
  output logic [NUM_REQ-1:0]         GNT_o,
  output logic [LED_NUM-1:0]         LED_o,
  output logic [OW-1:0]              OWNER_o,
  output logic                       BUSY_o
);

  localparam int HCW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int WCW = (WATER_TICKS > 1) ? $clog2(WATER_TICKS) : 1;

  if (HOLD_TICKS < 1 || WATER_TICKS < 1) begin : g_bad_ticks
    $error("led_bank_arbiter: HOLD_TICKS and WATER_TICKS must be >= 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || LED_NUM < 2) begin : g_bad_size
    $error("led_bank_arbiter: NUM_REQ must be 2..32 and LED_NUM >= 2");
  end

  logic               tick;
  state_e             state;
  logic [OW-1:0]      rr_last, idle_pick, open_pick;
  logic [NUM_REQ-1:0] others, idle_onehot, open_onehot;
  logic [LED_NUM-1:0] water, water_next, owner_pat, idle_pat, open_pat;
  logic [HCW-1:0]     hold_cnt;
  logic [WCW-1:0]     step_cnt, step_next;
  logic               step_done, hold_done;

  led_tick_gen #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) u_tick (
    .CLK_i  (CLK_i),
    .RSTn_i (RSTn_i),
    .tick   (tick)
  );

  // NOTE: full default before the override so no latch is inferred.
  always_comb begin
    others          = REQ_i;
    others[OWNER_o] = 1'b0;
  end

  // Idle search starts after rr_last; preemption search excludes the owner,
  // which is rr_last while busy.
  assign idle_pick   = OW'(rr_pick(MAX_REQ'(REQ_i), int'(rr_last), NUM_REQ));
  assign open_pick   = OW'(rr_pick(MAX_REQ'(others), int'(rr_last), NUM_REQ));
  assign idle_onehot = NUM_REQ'(1) << idle_pick;
  assign open_onehot = NUM_REQ'(1) << open_pick;
  assign idle_pat    = PAT_i[idle_pick*LED_NUM +: LED_NUM];
  assign open_pat    = PAT_i[open_pick*LED_NUM +: LED_NUM];
  assign owner_pat   = PAT_i[OWNER_o*LED_NUM +: LED_NUM];

  assign step_done  = tick && (step_cnt == WCW'(WATER_TICKS - 1));
  assign step_next  = !tick ? step_cnt : (step_done ? '0 : step_cnt + 1'b1);
  assign water_next = step_done ? {water[LED_NUM-2:0], water[LED_NUM-1]} : water;
  assign hold_done  = tick && (hold_cnt == HCW'(HOLD_TICKS - 1));

  always_ff @(posedge CLK_i) begin
    if (!RSTn_i) begin
      state    <= S_IDLE;
      LED_o    <= LED_NUM'(1);
      water    <= LED_NUM'(1);
      GNT_o    <= '0;
      BUSY_o   <= 1'b0;
      OWNER_o  <= '0;
      rr_last  <= OW'(NUM_REQ - 1);
      hold_cnt <= '0;
      step_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|REQ_i) begin
            // Grant edge: water position freezes, no tick is counted.
            state    <= S_HOLD;
            GNT_o    <= idle_onehot;
            OWNER_o  <= idle_pick;
            rr_last  <= idle_pick;
            BUSY_o   <= 1'b1;
            LED_o    <= idle_pat;
            hold_cnt <= '0;
            step_cnt <= '0;
          end else begin
            water    <= water_next;
            LED_o    <= water_next;
            step_cnt <= step_next;
          end
        end
        S_HOLD: begin
          LED_o <= owner_pat;
          if (tick) hold_cnt <= hold_cnt + 1'b1;
          if (hold_done) state <= S_OPEN;
        end
        S_OPEN: begin
          if (|others) begin
            state    <= S_HOLD;
            GNT_o    <= open_onehot;
            OWNER_o  <= open_pick;
            rr_last  <= open_pick;
            LED_o    <= open_pat;
            hold_cnt <= '0;
          end else if (!REQ_i[OWNER_o]) begin
            // Back to idle; a coincident tick already counts toward the next step.
            state    <= S_IDLE;
            GNT_o    <= '0;
            BUSY_o   <= 1'b0;
            water    <= water_next;
            LED_o    <= water_next;
            step_cnt <= step_next;
          end else begin
            LED_o <= owner_pat;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter: cycle model scoreboard plus
// a round-robin vector table and hand-written corner sequences.
module tb_led_bank_arbiter;

  localparam logic [31:0] PAT = 32'hD4C3_B2A5;  // req3..req0 = D4 C3 B2 A5

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req  = '0;
  logic [31:0] pat  = '0;
  logic [3:0]  gnt;
  logic [7:0]  led;
  logic [1:0]  owner;
  logic        busy;

  led_bank_arbiter #(
    .CLK_FREQ(1000), .TICK_HZ(100), .LED_NUM(8), .NUM_REQ(4),
    .HOLD_TICKS(3), .WATER_TICKS(2)
  ) dut (
    .CLK_i(clk), .RSTn_i(rstn), .REQ_i(req), .PAT_i(pat),
    .GNT_o(gnt), .LED_o(led), .OWNER_o(owner), .BUSY_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
  } out_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic [7:0] led;
  } vec_t;

  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state (0 idle, 1 hold, 2 open)
  int         m_state, m_owner, m_rr, m_hold, m_step, m_wpos, m_phase;
  logic [7:0] m_led;
  logic [3:0] m_gnt;
  logic       m_busy;

  vec_t        vt[5];
  int          seq_owner[$];
  int          seq_at[$];
  int          exp_order[5];
  logic [3:0]  last_gnt;
  logic [31:0] rnd_pat;
  int          n_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  task automatic m_take(input int w, input logic [31:0] p);
    m_state = 1;
    m_owner = w;
    m_rr    = w;
    m_gnt   = 4'b0001 << w;
    m_busy  = 1'b1;
    m_hold  = 0;
    m_step  = 0;
    m_led   = p[w*8 +: 8];
  endtask

  task automatic m_water(input bit tk);
    if (tk) begin
      m_step++;
      if (m_step == 2) begin
        m_step = 0;
        m_wpos = (m_wpos + 1) % 8;
      end
    end
    m_led = 8'h01 << m_wpos;
  endtask

  task automatic model_edge(input logic rn, input logic [3:0] r, input logic [31:0] p);
    bit         tk;
    logic [3:0] oth;
    out_t       e;
    if (!rn) begin
      m_state = 0; m_owner = 0; m_rr = 3; m_hold = 0; m_step = 0;
      m_wpos = 0; m_phase = 0; m_led = 8'h01; m_gnt = '0; m_busy = 1'b0;
    end else begin
      tk      = (m_phase == 9);
      m_phase = (m_phase + 1) % 10;
      case (m_state)
        0: begin
          if (r != 0) m_take(m_pick(r, m_rr), p);
          else m_water(tk);
        end
        1: begin
          m_led = p[m_owner*8 +: 8];
          if (tk) begin
            m_hold++;
            if (m_hold == 3) m_state = 2;
          end
        end
        default: begin
          oth = r;
          oth[m_owner] = 1'b0;
          if (oth != 0) m_take(m_pick(oth, m_rr), p);
          else if (!r[m_owner]) begin
            m_state = 0; m_gnt = '0; m_busy = 1'b0;
            m_water(tk);
          end else m_led = p[m_owner*8 +: 8];
        end
      endcase
    end
    e.led = m_led; e.gnt = m_gnt; e.owner = 2'(m_owner); e.busy = m_busy;
    exp_q.push_back(e);
  endtask

  // One clock: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic cycle(input logic rn, input logic [3:0] r, input logic [31:0] p);
    out_t e, a;
    @(negedge clk);
    rstn = rn;
    req  = r;
    pat  = p;
    model_edge(rn, r, p);
    @(posedge clk);
    #1;
    a.led = led; a.gnt = gnt; a.owner = owner; a.busy = busy;
    if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
    else begin
      e = exp_q.pop_front();
      check("sb", 32'(a), 32'(e));
    end
  endtask

  initial begin
    vt[0] = '{4'b0001, 4'b0001, 2'd0, 8'hA5};
    vt[1] = '{4'b0110, 4'b0010, 2'd1, 8'hB2};
    vt[2] = '{4'b1000, 4'b1000, 2'd3, 8'hD4};
    vt[3] = '{4'b1100, 4'b0100, 2'd2, 8'hC3};
    vt[4] = '{4'b1111, 4'b0001, 2'd0, 8'hA5};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset and idle running light with wrap
    repeat (3) cycle(1'b0, 4'b0000, 32'h0);
    check("rst_led", 32'(led), 32'h01);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    for (int i = 1; i <= 165; i++) begin
      cycle(1'b1, 4'b0000, PAT);
      if (i == 19)  check("water_before_step", 32'(led), 32'h01);
      if (i == 20)  check("water_first_step", 32'(led), 32'h02);
      if (i == 140) check("water_msb", 32'(led), 32'h80);
      if (i == 160) check("water_wrap", 32'(led), 32'h01);
    end

    // First winner after reset for several request patterns
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0000, PAT);
      cycle(1'b1, vt[i].req, PAT);
      check("rr_gnt", 32'(gnt), 32'(vt[i].gnt));
      check("rr_owner", 32'(owner), 32'(vt[i].owner));
      check("rr_led", 32'(led), 32'(vt[i].led));
      check("rr_busy", 32'(busy), 32'h1);
    end

    // Owner drops its request early; hold still runs, then water resumes frozen
    cycle(1'b0, 4'b0000, PAT);
    repeat (40) cycle(1'b1, 4'b0000, PAT);
    check("t2_water_pre", 32'(led), 32'h04);
    repeat (5) cycle(1'b1, 4'b0001, PAT);
    check("t2_gnt", 32'(gnt), 32'h1);
    check("t2_led", 32'(led), 32'hA5);
    n_wait = 0;
    while (busy && n_wait < 100) begin
      cycle(1'b1, 4'b0000, PAT);
      n_wait++;
    end
    check("t2_release_cycles", 32'(n_wait), 32'd26);
    check("t2_gnt_idle", 32'(gnt), 32'h0);
    check("t2_water_frozen", 32'(led), 32'h04);
    repeat (18) cycle(1'b1, 4'b0000, PAT);
    check("t2_water_hold", 32'(led), 32'h04);
    cycle(1'b1, 4'b0000, PAT);
    check("t2_water_resume", 32'(led), 32'h08);

    // All requesting: rotation order and grant length
    cycle(1'b0, 4'b0000, PAT);
    last_gnt = '0;
    for (int i = 1; i <= 135; i++) begin
      cycle(1'b1, 4'b1111, PAT);
      check("t3_onehot", 32'($countones(gnt) <= 1), 32'd1);
      if (gnt != last_gnt) begin
        seq_owner.push_back(int'(owner));
        seq_at.push_back(i);
        last_gnt = gnt;
      end
    end
    check("t3_grants", 32'(seq_owner.size()), 32'd5);
    for (int k = 0; k < seq_owner.size() && k < 5; k++)
      check("t3_order", 32'(seq_owner[k]), 32'(exp_order[k]));
    for (int k = 0; k + 1 < seq_at.size(); k++)
      check("t3_grant_len", 32'(seq_at[k+1] - seq_at[k]), 32'd30);

    // Lone owner 2 preempted by requester 1 (search wraps 3, 0, 1)
    cycle(1'b0, 4'b0000, PAT);
    repeat (100) cycle(1'b1, 4'b0100, PAT);
    check("t4_owner_before", 32'(owner), 32'd2);
    cycle(1'b1, 4'b0110, PAT);
    check("t4_owner_after", 32'(owner), 32'd1);
    check("t4_gnt_after", 32'(gnt), 32'h2);
    check("t4_led_after", 32'(led), 32'hB2);

    // Owner pattern changing every cycle appears one cycle later
    cycle(1'b0, 4'b0000, PAT);
    for (int i = 0; i < 25; i++) begin
      rnd_pat = $urandom;
      cycle(1'b1, 4'b0010, rnd_pat);
      check("t5_follow", 32'(led), 32'(rnd_pat[15:8]));
    end

    // Reset mid-hold, then simultaneous 3 and 0 requests
    cycle(1'b0, 4'b0000, PAT);
    repeat (15) cycle(1'b1, 4'b0100, PAT);
    check("t6_busy_pre", 32'(busy), 32'h1);
    cycle(1'b0, 4'b0100, PAT);
    check("t6_rst_led", 32'(led), 32'h01);
    check("t6_rst_gnt", 32'(gnt), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_owner", 32'(owner), 32'h0);
    cycle(1'b1, 4'b1001, PAT);
    check("t6_owner", 32'(owner), 32'd0);
    check("t6_gnt", 32'(gnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
